// File: rtl/line_write_merge.sv
// Store-merge buffer: folds 16-bit CPU stores into one 128-bit line and writes the
// line to physical memory with byte enables on a tag change or on a flush.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no line held; data, byte enables and tag are all zero
// S_HOLD  | one line held; stores with a matching tag merge into it
// S_DRAIN | pmem_write high; line frozen until pmem_resp clears it
module line_write_merge (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_write,
  input  logic [15:0]  cpu_addr,
  input  logic [15:0]  cpu_wdata,
  input  logic [1:0]   cpu_wmask,
  output logic         cpu_resp,
  input  logic         flush,
  output logic         flush_done,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic [15:0]  pmem_byte_en,
  input  logic         pmem_resp,
  output logic         line_valid
);

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [11:0]    tag_q, tag_d;
  logic [127:0]   data_q, data_d;
  logic [15:0]    ben_q, ben_d;
  logic           cpu_resp_q, cpu_resp_d;
  logic           flush_done_q, flush_done_d;
  logic           pmem_write_q, pmem_write_d;
  logic           line_valid_q, line_valid_d;

  logic           store_req;
  logic           flush_req;
  logic           tag_hit;
  logic [2:0]     lane;
  logic [127:0]   merge_data;
  logic [15:0]    merge_ben;

  // A request still held during its own acknowledge cycle must not be taken again.
  assign store_req = cpu_write & ~cpu_resp_q;
  assign flush_req = flush & ~flush_done_q;
  assign tag_hit   = (cpu_addr[15:4] == tag_q);
  assign lane      = cpu_addr[3:1];

  always_comb begin
    merge_data = data_q;
    merge_ben  = ben_q;
    if (cpu_wmask[0]) begin
      merge_data[{lane, 4'b0000} +: 8] = cpu_wdata[7:0];
      merge_ben[{lane, 1'b0}]          = 1'b1;
    end
    if (cpu_wmask[1]) begin
      merge_data[{lane, 4'b1000} +: 8] = cpu_wdata[15:8];
      merge_ben[{lane, 1'b1}]          = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    data_d       = data_q;
    ben_d        = ben_q;
    cpu_resp_d   = 1'b0;
    flush_done_d = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (flush_req) begin
          flush_done_d = 1'b1;
        end
        if (store_req) begin
          tag_d      = cpu_addr[15:4];
          data_d     = merge_data;
          ben_d      = merge_ben;
          cpu_resp_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Flush wins over a simultaneous store; the store waits for EMPTY.
        if (flush_req || (store_req && !tag_hit)) begin
          state_d = S_DRAIN;
        end else if (store_req) begin
          data_d     = merge_data;
          ben_d      = merge_ben;
          cpu_resp_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (pmem_resp) begin
          state_d = S_EMPTY;
          tag_d   = '0;
          data_d  = '0;
          ben_d   = '0;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    pmem_write_d = (state_d == S_DRAIN);
    line_valid_d = |ben_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      tag_q        <= '0;
      data_q       <= '0;
      ben_q        <= '0;
      cpu_resp_q   <= 1'b0;
      flush_done_q <= 1'b0;
      pmem_write_q <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      ben_q        <= ben_d;
      cpu_resp_q   <= cpu_resp_d;
      flush_done_q <= flush_done_d;
      pmem_write_q <= pmem_write_d;
      line_valid_q <= line_valid_d;
    end
  end

  assign cpu_resp     = cpu_resp_q;
  assign flush_done   = flush_done_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = {tag_q, 4'b0000};
  assign pmem_wdata   = data_q;
  assign pmem_byte_en = ben_q;
  assign line_valid   = line_valid_q;

endmodule

// File: tb/tb_line_write_merge.sv
// Directed bench for line_write_merge: stores, merges, drains, conflicts, flush and
// reset behaviour, each checked against hand-computed values.
module tb_line_write_merge;

  logic         clk;
  logic         rst_n;
  logic         cpu_write;
  logic [15:0]  cpu_addr;
  logic [15:0]  cpu_wdata;
  logic [1:0]   cpu_wmask;
  logic         cpu_resp;
  logic         flush;
  logic         flush_done;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [15:0]  pmem_byte_en;
  logic         pmem_resp;
  logic         line_valid;

  int n_assert;
  int n_fail;

  line_write_merge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_write    (cpu_write),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wmask    (cpu_wmask),
    .cpu_resp     (cpu_resp),
    .flush        (flush),
    .flush_done   (flush_done),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_byte_en (pmem_byte_en),
    .pmem_resp    (pmem_resp),
    .line_valid   (line_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_resp"},  128'(cpu_resp), 128'd0);
    chk({name, "_fdone"}, 128'(flush_done), 128'd0);
    chk({name, "_pwr"},   128'(pmem_write), 128'd0);
    chk({name, "_paddr"}, 128'(pmem_address), 128'd0);
    chk({name, "_pdata"}, pmem_wdata, 128'd0);
    chk({name, "_pben"},  128'(pmem_byte_en), 128'd0);
    chk({name, "_lv"},    128'(line_valid), 128'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_wmask = '0;
    flush     = 1'b0;
    pmem_resp = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] mask);
    logic got;
    got       = 1'b0;
    cpu_write = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wmask = mask;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (cpu_resp) got = 1'b1;
    end
    chk("store_ack", 128'(got), 128'd1);
    cpu_write = 1'b0;
    cpu_wmask = 2'b00;
    tick();
    chk("resp_one_cycle", 128'(cpu_resp), 128'd0);
  endtask

  task automatic do_flush_drain(input logic [15:0] exp_addr, input logic [15:0] exp_ben,
                                input logic [127:0] exp_data, input int delay);
    flush = 1'b1;
    tick();
    chk("drain_pwr", 128'(pmem_write), 128'd1);
    chk("drain_addr", 128'(pmem_address), 128'(exp_addr));
    chk("drain_ben", 128'(pmem_byte_en), 128'(exp_ben));
    chk("drain_data", pmem_wdata, exp_data);
    chk("drain_fdone_early", 128'(flush_done), 128'd0);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("drain_hold_pwr", 128'(pmem_write), 128'd1);
      chk("drain_hold_ben", 128'(pmem_byte_en), 128'(exp_ben));
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("drain_end_pwr", 128'(pmem_write), 128'd0);
    chk("drain_end_ben", 128'(pmem_byte_en), 128'd0);
    chk("drain_end_lv", 128'(line_valid), 128'd0);
    tick();
    chk("flush_done_pulse", 128'(flush_done), 128'd1);
    chk("flush_done_pwr", 128'(pmem_write), 128'd0);
    flush = 1'b0;
    tick();
    chk("flush_done_drop", 128'(flush_done), 128'd0);
  endtask

  task automatic do_flush_empty();
    flush = 1'b1;
    tick();
    chk("eflush_done", 128'(flush_done), 128'd1);
    chk("eflush_pwr", 128'(pmem_write), 128'd0);
    flush = 1'b0;
    tick();
    chk("eflush_drop", 128'(flush_done), 128'd0);
    chk("eflush_pwr2", 128'(pmem_write), 128'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    do_reset();

    // Single word store at offset 3
    do_store(16'h1236, 16'hBEEF, 2'b11);
    chk("t1_ben", 128'(pmem_byte_en), 128'h00C0);
    chk("t1_lv", 128'(line_valid), 128'd1);
    do_flush_drain(16'h1230, 16'h00C0, {64'h0, 16'hBEEF, 48'h0}, 2);

    // Two byte stores into the top word, minimum-length drain
    do_store(16'h200E, 16'h00AA, 2'b01);
    chk("t2_ben_lo", 128'(pmem_byte_en), 128'h4000);
    do_store(16'h200E, 16'hBB00, 2'b10);
    do_flush_drain(16'h2000, 16'hC000, {16'hBBAA, 112'h0}, 0);

    // Full line of word stores
    for (int k = 0; k < 8; k++) begin
      do_store(16'h4000 + 16'(2 * k), 16'(16'h1111 * (k + 1)), 2'b11);
    end
    do_flush_drain(16'h4000, 16'hFFFF,
                   128'h8888_7777_6666_5555_4444_3333_2222_1111, 1);

    // Conflict eviction; a stray pmem_resp in HOLD must be ignored
    do_store(16'h3000, 16'h1234, 2'b11);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t4_stray_ben", 128'(pmem_byte_en), 128'h0003);
    chk("t4_stray_pwr", 128'(pmem_write), 128'd0);
    cpu_write = 1'b1;
    cpu_addr  = 16'h5002;
    cpu_wdata = 16'hCAFE;
    cpu_wmask = 2'b11;
    tick();
    chk("t4_pwr", 128'(pmem_write), 128'd1);
    chk("t4_noresp", 128'(cpu_resp), 128'd0);
    chk("t4_addr", 128'(pmem_address), 128'h3000);
    chk("t4_ben", 128'(pmem_byte_en), 128'h0003);
    chk("t4_data", pmem_wdata, 128'h1234);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_wait_pwr", 128'(pmem_write), 128'd1);
      chk("t4_wait_noresp", 128'(cpu_resp), 128'd0);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t4_exit_pwr", 128'(pmem_write), 128'd0);
    chk("t4_exit_noresp", 128'(cpu_resp), 128'd0);
    tick();
    chk("t4_accept", 128'(cpu_resp), 128'd1);
    cpu_write = 1'b0;
    cpu_wmask = 2'b00;
    chk("t4_new_addr", 128'(pmem_address), 128'h5000);
    chk("t4_new_ben", 128'(pmem_byte_en), 128'h000C);
    chk("t4_new_lv", 128'(line_valid), 128'd1);
    tick();
    chk("t4_resp_drop", 128'(cpu_resp), 128'd0);
    do_flush_drain(16'h5000, 16'h000C, {96'h0, 16'hCAFE, 16'h0}, 0);

    // Flush and same-tag store together while holding a line
    do_store(16'h6000, 16'h0101, 2'b11);
    flush     = 1'b1;
    cpu_write = 1'b1;
    cpu_addr  = 16'h6004;
    cpu_wdata = 16'h0202;
    cpu_wmask = 2'b11;
    tick();
    chk("t5_pwr", 128'(pmem_write), 128'd1);
    chk("t5_ben", 128'(pmem_byte_en), 128'h0003);
    chk("t5_data", pmem_wdata, 128'h0101);
    chk("t5_noresp", 128'(cpu_resp), 128'd0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t5_exit_pwr", 128'(pmem_write), 128'd0);
    chk("t5_exit_fdone", 128'(flush_done), 128'd0);
    tick();
    chk("t5_fdone", 128'(flush_done), 128'd1);
    chk("t5_resp", 128'(cpu_resp), 128'd1);
    chk("t5_ben_new", 128'(pmem_byte_en), 128'h0030);
    chk("t5_lv", 128'(line_valid), 128'd1);
    flush     = 1'b0;
    cpu_write = 1'b0;
    cpu_wmask = 2'b00;
    tick();
    chk("t5_fdone_drop", 128'(flush_done), 128'd0);
    chk("t5_resp_drop", 128'(cpu_resp), 128'd0);
    // Empty mask on a held line is acknowledged and changes nothing
    do_store(16'h6004, 16'hFFFF, 2'b00);
    chk("t5_nomask_ben", 128'(pmem_byte_en), 128'h0030);
    do_flush_drain(16'h6000, 16'h0030, {80'h0, 16'h0202, 32'h0}, 0);

    // Empty mask from EMPTY captures the tag but leaves the line invalid
    do_store(16'h8002, 16'h1234, 2'b00);
    chk("t6_lv", 128'(line_valid), 128'd0);
    chk("t6_addr", 128'(pmem_address), 128'h8000);
    chk("t6_ben", 128'(pmem_byte_en), 128'h0000);
    do_reset();

    // Reset while draining
    do_store(16'h7000, 16'h5555, 2'b11);
    flush = 1'b1;
    tick();
    chk("t7_pwr", 128'(pmem_write), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_pwr", 128'(pmem_write), 128'd0);
    chk("t7_rst_ben", 128'(pmem_byte_en), 128'd0);
    chk("t7_rst_lv", 128'(line_valid), 128'd0);
    flush = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_flush_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
